// File: rtl/bank_out_merge.sv
// rtl/bank_out_merge.sv - merges the M0/M1 read-return streams into one {payload, src} tagged stream
// Optional BANK_MERGE_RR_EN selects round-robin arbitration; otherwise M0 has fixed priority.
module bank_out_merge #(
  parameter int DATA_WIDTH = 8,
  parameter int QDEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid_M0,
  input  logic [DATA_WIDTH-1:0]            data_M0,
  input  logic                             valid_M1,
  input  logic [DATA_WIDTH-1:0]            data_M1,
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [DATA_WIDTH:0]              out_data,
  output logic [$clog2(QDEPTH+1)-1:0]      cnt_M0,
  output logic [$clog2(QDEPTH+1)-1:0]      cnt_M1,
  output logic                             ovf_M0,
  output logic                             ovf_M1
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  logic [DATA_WIDTH-1:0] mem0 [QDEPTH];
  logic [DATA_WIDTH-1:0] mem1 [QDEPTH];
  logic [PW-1:0]         rd0, wr0, rd1, wr1;

  logic load;
  logic ne0, ne1, full0, full1;
  logic grant0, grant1;
  logic push0, push1, drop0, drop1;

  assign ne0   = (cnt_M0 != '0);
  assign ne1   = (cnt_M1 != '0);
  assign full0 = (cnt_M0 == FULL);
  assign full1 = (cnt_M1 == FULL);
  assign load  = !out_valid || out_ready;

`ifdef BANK_MERGE_RR_EN
  // Resets to "M1 granted last" so that M0 wins the first contention.
  logic last_m1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_m1 <= 1'b1;
    end else if (grant0) begin
      last_m1 <= 1'b0;
    end else if (grant1) begin
      last_m1 <= 1'b1;
    end
  end

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (load) begin
      if (ne0 && ne1) begin
        grant0 = last_m1;
        grant1 = !last_m1;
      end else begin
        grant0 = ne0;
        grant1 = ne1;
      end
    end
  end
`else
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (load) begin
      grant0 = ne0;
      grant1 = !ne0 && ne1;
    end
  end
`endif

  // A full queue still accepts a word on the cycle its head leaves.
  assign push0 = valid_M0 && (!full0 || grant0);
  assign push1 = valid_M1 && (!full1 || grant1);
  assign drop0 = valid_M0 && full0 && !grant0;
  assign drop1 = valid_M1 && full1 && !grant1;

  always_ff @(posedge clk) begin
    if (push0) begin
      mem0[wr0] <= data_M0;
    end
    if (push1) begin
      mem1[wr1] <= data_M1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd0    <= '0;
      wr0    <= '0;
      cnt_M0 <= '0;
      ovf_M0 <= 1'b0;
    end else begin
      if (push0) begin
        wr0 <= wr0 + 1'b1;
      end
      if (grant0) begin
        rd0 <= rd0 + 1'b1;
      end
      case ({push0, grant0})
        2'b10:   cnt_M0 <= cnt_M0 + 1'b1;
        2'b01:   cnt_M0 <= cnt_M0 - 1'b1;
        default: cnt_M0 <= cnt_M0;
      endcase
      if (drop0) begin
        ovf_M0 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1    <= '0;
      wr1    <= '0;
      cnt_M1 <= '0;
      ovf_M1 <= 1'b0;
    end else begin
      if (push1) begin
        wr1 <= wr1 + 1'b1;
      end
      if (grant1) begin
        rd1 <= rd1 + 1'b1;
      end
      case ({push1, grant1})
        2'b10:   cnt_M1 <= cnt_M1 + 1'b1;
        2'b01:   cnt_M1 <= cnt_M1 - 1'b1;
        default: cnt_M1 <= cnt_M1;
      endcase
      if (drop1) begin
        ovf_M1 <= 1'b1;
      end
    end
  end

  // Payload is left as-is when the register empties; only out_valid clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      if (grant0) begin
        out_valid <= 1'b1;
        out_data  <= {mem0[rd0], 1'b0};
      end else if (grant1) begin
        out_valid <= 1'b1;
        out_data  <= {mem1[rd1], 1'b1};
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bank_out_merge.sv
// tb/tb_bank_out_merge.sv - randomized and directed bench for bank_out_merge against a queue-level model
module tb_bank_out_merge;

  localparam int DW = 8;
  localparam int QD = 4;

  logic          clk;
  logic          rst;
  logic          valid_M0, valid_M1, out_ready;
  logic [DW-1:0] data_M0, data_M1;
  logic          out_valid;
  logic [DW:0]   out_data;
  logic [2:0]    cnt_M0, cnt_M1;
  logic          ovf_M0, ovf_M1;

  int checks = 0;
  int errors = 0;

  bank_out_merge #(.DATA_WIDTH(DW), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .valid_M0(valid_M0), .data_M0(data_M0),
    .valid_M1(valid_M1), .data_M1(data_M1),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .cnt_M0(cnt_M0), .cnt_M1(cnt_M1), .ovf_M0(ovf_M0), .ovf_M1(ovf_M1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per source plus the output register.
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  logic          m_ov;
  logic [DW:0]   m_od;
  logic          m_ovf0, m_ovf1;
`ifdef BANK_MERGE_RR_EN
  int            m_last;
`endif

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_ov = 1'b0;
    m_od = '0;
    m_ovf0 = 1'b0;
    m_ovf1 = 1'b0;
`ifdef BANK_MERGE_RR_EN
    m_last = 1;
`endif
  endtask

  task automatic model_step();
    int g;
    g = -1;
    if (!m_ov || out_ready) begin
      if (q0.size() > 0 && q1.size() > 0) begin
`ifdef BANK_MERGE_RR_EN
        g = (m_last == 1) ? 0 : 1;
`else
        g = 0;
`endif
      end else if (q0.size() > 0) begin
        g = 0;
      end else if (q1.size() > 0) begin
        g = 1;
      end
      if (g == 0) begin
        m_od = {q0.pop_front(), 1'b0};
        m_ov = 1'b1;
      end else if (g == 1) begin
        m_od = {q1.pop_front(), 1'b1};
        m_ov = 1'b1;
      end else begin
        m_ov = 1'b0;
      end
`ifdef BANK_MERGE_RR_EN
      if (g >= 0) m_last = g;
`endif
    end
    if (valid_M0) begin
      if (q0.size() < QD) q0.push_back(data_M0);
      else m_ovf0 = 1'b1;
    end
    if (valid_M1) begin
      if (q1.size() < QD) q1.push_back(data_M1);
      else m_ovf1 = 1'b1;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_M0 = 1'b0;
    valid_M1 = 1'b0;
    data_M0 = '0;
    data_M1 = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle_inputs();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, cnt_M0, cnt_M1, ovf_M0, ovf_M1} !== '0) begin
      errors++;
      $display("FAIL reset_values: got v=%0b d=%h c0=%0d c1=%0d o0=%0b o1=%0b, want all 0",
               out_valid, out_data, cnt_M0, cnt_M1, ovf_M0, ovf_M1);
    end
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    reset_dut();
    valid_M0 = 1'b1;
    data_M0 = 8'h3C;
    cycle();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b0 || cnt_M0 !== 3'd1) begin
      errors++;
      $display("FAIL single_enqueue: got v=%0b c0=%0d, want v=0 c0=1", out_valid, cnt_M0);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 9'h078) begin
      errors++;
      $display("FAIL single_grant: got v=%0b d=%h, want v=1 d=078", out_valid, out_data);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got v=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_simultaneous();
    reset_dut();
    valid_M0 = 1'b1;
    data_M0 = 8'h11;
    valid_M1 = 1'b1;
    data_M1 = 8'h22;
    cycle();
    idle_inputs();
    checks++;
    if (cnt_M0 !== 3'd1 || cnt_M1 !== 3'd1) begin
      errors++;
      $display("FAIL simul_push: got c0=%0d c1=%0d, want 1 1", cnt_M0, cnt_M1);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 9'h022) begin
      errors++;
      $display("FAIL simul_first: got v=%0b d=%h, want v=1 d=022", out_valid, out_data);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 9'h045) begin
      errors++;
      $display("FAIL simul_second: got v=%0b d=%h, want v=1 d=045", out_valid, out_data);
    end
  endtask

  task automatic test_contention();
    logic [DW:0] exp_seq [6];
`ifdef BANK_MERGE_RR_EN
    exp_seq = '{9'h002, 9'h143, 9'h004, 9'h145, 9'h006, 9'h147};
`else
    exp_seq = '{9'h002, 9'h004, 9'h006, 9'h143, 9'h145, 9'h147};
`endif
    reset_dut();
    for (int i = 0; i < 7; i++) begin
      if (i < 3) begin
        valid_M0 = 1'b1;
        data_M0 = 8'(i + 1);
        valid_M1 = 1'b1;
        data_M1 = 8'(8'hA1 + i);
      end else begin
        idle_inputs();
      end
      cycle();
      if (i >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_seq[i-1]) begin
          errors++;
          $display("FAIL contention[%0d]: got v=%0b d=%h, want v=1 d=%h", i - 1, out_valid, out_data, exp_seq[i-1]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_overflow();
    reset_dut();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid_M1 = 1'b1;
      data_M1 = 8'(8'h10 + i);
      cycle();
    end
    idle_inputs();
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 9'h021 || cnt_M1 !== 3'd4 || ovf_M1 !== 1'b1 || ovf_M0 !== 1'b0) begin
      errors++;
      $display("FAIL overflow: got v=%0b d=%h c1=%0d o1=%0b o0=%0b, want v=1 d=021 c1=4 o1=1 o0=0",
               out_valid, out_data, cnt_M1, ovf_M1, ovf_M0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== {8'(8'h11 + i), 1'b1}) begin
        errors++;
        $display("FAIL overflow_drain[%0d]: got v=%0b d=%h, want v=1 d=%h", i, out_valid, out_data, {8'(8'h11 + i), 1'b1});
      end
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0 || ovf_M1 !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got v=%0b o1=%0b, want v=0 o1=1", out_valid, ovf_M1);
    end
  endtask

  task automatic test_push_pop_full();
    reset_dut();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_M0 = 1'b1;
      data_M0 = 8'(8'h40 + i);
      cycle();
    end
    checks++;
    if (cnt_M0 !== 3'd4 || out_data !== 9'h080) begin
      errors++;
      $display("FAIL full_fill: got c0=%0d d=%h, want c0=4 d=080", cnt_M0, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid_M0 = 1'b1;
      data_M0 = 8'(8'h45 + i);
      cycle();
      checks++;
      if (cnt_M0 !== 3'd4 || ovf_M0 !== 1'b0 || out_valid !== 1'b1 || out_data !== {8'(8'h41 + i), 1'b0}) begin
        errors++;
        $display("FAIL full_pushpop[%0d]: got c0=%0d o0=%0b v=%0b d=%h, want c0=4 o0=0 v=1 d=%h",
                 i, cnt_M0, ovf_M0, out_valid, out_data, {8'(8'h41 + i), 1'b0});
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int bad;
    reset_dut();
    bad = 0;
    for (int n = 0; n < 3000; n++) begin
      valid_M0 = ($urandom_range(0, 99) < 45);
      valid_M1 = ($urandom_range(0, 99) < 45);
      data_M0 = 8'($urandom_range(0, 255));
      data_M1 = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 80 : 40));
      cycle();
      checks++;
      if ({out_valid, out_data, cnt_M0, cnt_M1, ovf_M0, ovf_M1} !==
          {m_ov, m_od, 3'(q0.size()), 3'(q1.size()), m_ovf0, m_ovf1}) begin
        errors++;
        if (bad < 10)
          $display("FAIL random[%0d]: got v=%0b d=%h c0=%0d c1=%0d o0=%0b o1=%0b, want v=%0b d=%h c0=%0d c1=%0d o0=%0b o1=%0b",
                   n, out_valid, out_data, cnt_M0, cnt_M1, ovf_M0, ovf_M1,
                   m_ov, m_od, q0.size(), q1.size(), m_ovf0, m_ovf1);
        bad++;
      end
    end
    idle_inputs();
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    reset_dut();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_M0 = 1'b1;
      valid_M1 = 1'b1;
      data_M0 = 8'($urandom_range(0, 255));
      data_M1 = 8'($urandom_range(0, 255));
      cycle();
    end
    checks++;
    if (out_valid !== 1'b1 || cnt_M0 === 3'd0 || cnt_M1 === 3'd0) begin
      errors++;
      $display("FAIL midrst_setup: got v=%0b c0=%0d c1=%0d, want v=1 and both counts nonzero", out_valid, cnt_M0, cnt_M1);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_data, cnt_M0, cnt_M1, ovf_M0, ovf_M1} !== '0) begin
      errors++;
      $display("FAIL midrst_async: got v=%0b d=%h c0=%0d c1=%0d o0=%0b o1=%0b, want all 0",
               out_valid, out_data, cnt_M0, cnt_M1, ovf_M0, ovf_M1);
    end
    idle_inputs();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    d = 8'($urandom_range(0, 255));
    valid_M1 = 1'b1;
    data_M1 = d;
    cycle();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b0 || cnt_M1 !== 3'd1) begin
      errors++;
      $display("FAIL midrst_enqueue: got v=%0b c1=%0d, want v=0 c1=1", out_valid, cnt_M1);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== {d, 1'b1}) begin
      errors++;
      $display("FAIL midrst_latency: got v=%0b d=%h, want v=1 d=%h", out_valid, out_data, {d, 1'b1});
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    out_ready = 1'b1;
    model_reset();
    test_reset();
    test_single_word();
    test_simultaneous();
    test_contention();
    test_overflow();
    test_push_pop_full();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
